gemm_tile_engine: RTL and testbench

//  Self-sequencing signed-integer GEMM tile: ROWS x COLS output-stationary systolic array with internal input skew,
//  K-beat streaming load, flush, and column-serial result drain over valid/ready handshakes.

---
 rtl/gemm_tile_engine.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_gemm_tile_engine.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gemm_tile_engine.sv
// gemm_tile_engine: output-stationary ROWS x COLS signed GEMM tile, skewed K-beat load, column-serial drain.
// Optional GEMM_SAT_EN: saturating accumulators with sticky per-PE flags exposed on o_sat.
module gemm_tile_engine #(
    parameter int ROWS       = 2,
    parameter int COLS       = 2,
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40,
    localparam int CW        = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic                       i_last,
    input  logic [ROWS*DATA_WIDTH-1:0] i_data_x,
    input  logic [COLS*DATA_WIDTH-1:0] i_data_w,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [ROWS*ACC_WIDTH-1:0]  o_data_acc,
    output logic [CW-1:0]              o_col,
    output logic                       o_last,
`ifdef GEMM_SAT_EN
    output logic [ROWS-1:0]            o_sat,
`endif
    output logic                       o_busy
);

    localparam int DW = DATA_WIDTH;
    localparam int AW = ACC_WIDTH;
    localparam int FW = $clog2(ROWS + COLS);

    if (ACC_WIDTH < 2 * DATA_WIDTH) begin : g_width_check
        $error("ACC_WIDTH must be at least 2*DATA_WIDTH");
    end

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DRAIN} state_e;

    state_e        state_q, state_d;
    logic [FW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] col_q, col_d;
    logic          accept;
    logic          start;

    logic signed [DW-1:0] x_bus   [ROWS][COLS];
    logic                 tx_bus  [ROWS][COLS];
    logic signed [DW-1:0] w_bus   [ROWS][COLS];
    logic                 tw_bus  [ROWS][COLS];
    logic signed [AW-1:0] acc_all [ROWS][COLS];
`ifdef GEMM_SAT_EN
    logic                 sat_all [ROWS][COLS];
`endif

    assign o_ready = (state_q == S_IDLE) || (state_q == S_LOAD);
    assign accept  = i_valid && o_ready;
    assign start   = accept && (state_q == S_IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        col_d   = col_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = i_last ? S_FLUSH : S_LOAD;
                    cnt_d   = '0;
                end
            end
            S_LOAD: begin
                if (accept && i_last) begin
                    state_d = S_FLUSH;
                    cnt_d   = '0;
                end
            end
            S_FLUSH: begin
                // Last PE accumulates one cycle before the final count
                if (cnt_q == FW'(ROWS + COLS - 1)) begin
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (i_ready) begin
                    if (col_q == CW'(COLS - 1)) begin
                        state_d = S_IDLE;
                        col_d   = '0;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            col_q   <= col_d;
        end
    end

    // Row lane i sees i extra register stages so beats meet diagonally
    for (genvar i = 0; i < ROWS; i++) begin : g_xskew
        logic [(i+1)*DW-1:0] d_q, d_d;
        logic [i:0]          t_q, t_d;
        logic [DW-1:0]       lane;

        assign lane = accept ? i_data_x[(ROWS-i)*DW-1 -: DW] : '0;

        always_comb begin
            d_d = ((i + 1) * DW)'({d_q, lane});
            t_d = (i + 1)'({t_q, accept});
        end

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                d_q <= '0;
                t_q <= '0;
            end else begin
                d_q <= d_d;
                t_q <= t_d;
            end
        end

        assign x_bus[i][0]  = d_q[(i+1)*DW-1 -: DW];
        assign tx_bus[i][0] = t_q[i];
    end

    for (genvar j = 0; j < COLS; j++) begin : g_wskew
        logic [(j+1)*DW-1:0] d_q, d_d;
        logic [j:0]          t_q, t_d;
        logic [DW-1:0]       lane;

        assign lane = accept ? i_data_w[(COLS-j)*DW-1 -: DW] : '0;

        always_comb begin
            d_d = ((j + 1) * DW)'({d_q, lane});
            t_d = (j + 1)'({t_q, accept});
        end

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                d_q <= '0;
                t_q <= '0;
            end else begin
                d_q <= d_d;
                t_q <= t_d;
            end
        end

        assign w_bus[0][j]  = d_q[(j+1)*DW-1 -: DW];
        assign tw_bus[0][j] = t_q[j];
    end

    for (genvar i = 0; i < ROWS; i++) begin : g_row
        for (genvar j = 0; j < COLS; j++) begin : g_col
            logic signed [2*DW-1:0] prod;
            logic signed [AW-1:0]   prod_ext;
            logic                   hit;
            logic signed [AW-1:0]   acc_q, acc_d;

            assign prod     = x_bus[i][j] * w_bus[i][j];
            assign prod_ext = AW'(prod);
            assign hit      = tx_bus[i][j] & tw_bus[i][j];

            if (j < COLS - 1) begin : g_xreg
                logic signed [DW-1:0] x_q, x_d;
                logic                 tx_q, tx_d;

                always_comb begin
                    x_d  = x_bus[i][j];
                    tx_d = tx_bus[i][j];
                end

                always_ff @(posedge i_clk) begin
                    if (i_rst) begin
                        x_q  <= '0;
                        tx_q <= 1'b0;
                    end else begin
                        x_q  <= x_d;
                        tx_q <= tx_d;
                    end
                end

                assign x_bus[i][j+1]  = x_q;
                assign tx_bus[i][j+1] = tx_q;
            end

            if (i < ROWS - 1) begin : g_wreg
                logic signed [DW-1:0] w_q, w_d;
                logic                 tw_q, tw_d;

                always_comb begin
                    w_d  = w_bus[i][j];
                    tw_d = tw_bus[i][j];
                end

                always_ff @(posedge i_clk) begin
                    if (i_rst) begin
                        w_q  <= '0;
                        tw_q <= 1'b0;
                    end else begin
                        w_q  <= w_d;
                        tw_q <= tw_d;
                    end
                end

                assign w_bus[i+1][j]  = w_q;
                assign tw_bus[i+1][j] = tw_q;
            end

`ifdef GEMM_SAT_EN
            logic              sat_q, sat_d;
            logic signed [AW:0] sum;

            assign sum = {acc_q[AW-1], acc_q} + {prod_ext[AW-1], prod_ext};

            always_comb begin
                acc_d = acc_q;
                sat_d = sat_q;
                if (start) begin
                    acc_d = '0;
                    sat_d = 1'b0;
                end else if (hit) begin
                    // Carry-out disagreeing with sign bit means overflow
                    if (sum[AW] != sum[AW-1]) begin
                        acc_d = sum[AW] ? {1'b1, {(AW-1){1'b0}}}
                                        : {1'b0, {(AW-1){1'b1}}};
                        sat_d = 1'b1;
                    end else begin
                        acc_d = sum[AW-1:0];
                    end
                end
            end

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    acc_q <= '0;
                    sat_q <= 1'b0;
                end else begin
                    acc_q <= acc_d;
                    sat_q <= sat_d;
                end
            end

            assign sat_all[i][j] = sat_q;
`else
            always_comb begin
                acc_d = acc_q;
                if (start) begin
                    acc_d = '0;
                end else if (hit) begin
                    acc_d = acc_q + prod_ext;
                end
            end

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    acc_q <= '0;
                end else begin
                    acc_q <= acc_d;
                end
            end
`endif

            assign acc_all[i][j] = acc_q;
        end
    end

    assign o_valid = (state_q == S_DRAIN);
    assign o_busy  = (state_q != S_IDLE);
    assign o_col   = col_q;
    assign o_last  = o_valid && (col_q == CW'(COLS - 1));

    for (genvar i = 0; i < ROWS; i++) begin : g_out
        assign o_data_acc[(ROWS-i)*AW-1 -: AW] = o_valid ? acc_all[i][col_q] : '0;
`ifdef GEMM_SAT_EN
        assign o_sat[ROWS-1-i] = o_valid ? sat_all[i][col_q] : 1'b0;
`endif
    end

endmodule

// File: tb/tb_gemm_tile_engine.sv
// Scoreboard bench for gemm_tile_engine (2x2, 8-bit operands, 20-bit accumulators).
module tb_gemm_tile_engine;

    localparam int R  = 2;
    localparam int C  = 2;
    localparam int DW = 8;
    localparam int AW = 20;
`ifdef GEMM_SAT_EN
    localparam int OVF = 524287;
`else
    localparam int OVF = -524288;
`endif

    typedef struct {
        logic [AW-1:0] c0;
        logic [AW-1:0] c1;
        int            col;
        bit            last;
        logic [1:0]    sat;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            i_valid;
    logic            o_ready;
    logic            i_last;
    logic [R*DW-1:0] dx;
    logic [C*DW-1:0] dw;
    logic            o_valid;
    logic            i_ready;
    logic [R*AW-1:0] o_data_acc;
    logic [0:0]      o_col;
    logic            o_last;
    logic            o_busy;
`ifdef GEMM_SAT_EN
    logic [R-1:0]    o_sat;
`endif

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   lat;

    always #5 clk = ~clk;

    gemm_tile_engine #(
        .ROWS(R), .COLS(C), .DATA_WIDTH(DW), .ACC_WIDTH(AW)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .i_last(i_last),
        .i_data_x(dx),
        .i_data_w(dw),
        .o_valid(o_valid),
        .i_ready(i_ready),
        .o_data_acc(o_data_acc),
        .o_col(o_col),
        .o_last(o_last),
`ifdef GEMM_SAT_EN
        .o_sat(o_sat),
`endif
        .o_busy(o_busy)
    );

    task automatic chk(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int c0, input int c1, input int col,
                        input bit last, input logic [1:0] sat);
        exp_t e;
        e.c0   = AW'(c0);
        e.c1   = AW'(c1);
        e.col  = col;
        e.last = last;
        e.sat  = sat;
        sb.push_back(e);
    endtask

    task automatic send(input int x0, input int x1, input int w0, input int w1,
                        input bit last);
        int n = 0;
        i_valid = 1'b1;
        i_last  = last;
        dx      = {8'(x0), 8'(x1)};
        dw      = {8'(w0), 8'(w1)};
        while (!o_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("send_ready", o_ready, 1);
        @(posedge clk); #1;
        i_valid = 1'b0;
        i_last  = 1'b0;
        dx      = '0;
        dw      = '0;
    endtask

    task automatic wait_valid(output int l);
        l = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (o_valid) begin
                l = c;
                break;
            end
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (o_busy && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_timeout", o_busy, 0);
    endtask

    task automatic basic_tile();
        push(19, 43, 0, 1'b0, 2'b00);
        push(22, 50, 1, 1'b1, 2'b00);
        send(1, 3, 5, 6, 1'b0);
        send(2, 4, 7, 8, 1'b1);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (o_valid && i_ready) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", sb.size(), 1);
            end else begin
                e = sb.pop_front();
                chk("drain_c0", o_data_acc[2*AW-1 -: AW], e.c0);
                chk("drain_c1", o_data_acc[AW-1:0], e.c1);
                chk("drain_col", o_col, e.col);
                chk("drain_last", o_last, e.last);
                chk("drain_ready", o_ready, 0);
`ifdef GEMM_SAT_EN
                chk("drain_sat", o_sat, e.sat);
`endif
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        i_valid = 1'b0;
        i_last  = 1'b0;
        dx      = '0;
        dw      = '0;
        i_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_valid", o_valid, 0);
        chk("rst_last", o_last, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_col", o_col, 0);
        chk("rst_acc", o_data_acc, 0);
        chk("rst_ready", o_ready, 1);

        // Basic tile and latency
        basic_tile();
        chk("flush_ready", o_ready, 0);
        chk("flush_busy", o_busy, 1);
        wait_valid(lat);
        chk("basic_latency", lat, 4);
        wait_idle();

        // Single-beat tile with signed operands
        push(-12, 8, 0, 1'b0, 2'b00);
        push(15, -10, 1, 1'b1, 2'b00);
        send(-3, 2, 4, -5, 1'b1);
        wait_valid(lat);
        chk("single_latency", lat, 4);
        wait_idle();

        // Bubbles in LOAD, junk i_valid during FLUSH
        push(19, 43, 0, 1'b0, 2'b00);
        push(22, 50, 1, 1'b1, 2'b00);
        send(1, 3, 5, 6, 1'b0);
        repeat (3) begin
            chk("bubble_ready", o_ready, 1);
            chk("bubble_busy", o_busy, 1);
            @(posedge clk); #1;
        end
        send(2, 4, 7, 8, 1'b1);
        i_valid = 1'b1;
        i_last  = 1'b1;
        dx      = {8'd100, 8'd100};
        dw      = {8'd100, 8'd100};
        wait_valid(lat);
        i_valid = 1'b0;
        i_last  = 1'b0;
        dx      = '0;
        dw      = '0;
        chk("bubble_latency", lat, 4);
        wait_idle();

        // Backpressure on column 0
        i_ready = 1'b0;
        basic_tile();
        wait_valid(lat);
        chk("bp_latency", lat, 4);
        repeat (3) begin
            chk("hold_c0", o_data_acc[2*AW-1 -: AW], 19);
            chk("hold_c1", o_data_acc[AW-1:0], 43);
            chk("hold_col", o_col, 0);
            chk("hold_last", o_last, 0);
            @(posedge clk); #1;
        end
        i_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_next_col", o_col, 1);
        chk("bp_next_valid", o_valid, 1);
        wait_idle();

        // Back-to-back tile, no carry-over
        push(1, 1, 0, 1'b0, 2'b00);
        push(1, 1, 1, 1'b1, 2'b00);
        send(1, 1, 1, 1, 1'b1);
        wait_valid(lat);
        wait_idle();

        // Reset during LOAD
        send(1, 3, 5, 6, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_busy", o_busy, 0);
        chk("mid_rst_ready", o_ready, 1);
        chk("mid_rst_valid", o_valid, 0);
        chk("mid_rst_col", o_col, 0);
        chk("mid_rst_acc", o_data_acc, 0);
        chk("mid_rst_last", o_last, 0);
        basic_tile();
        wait_valid(lat);
        chk("post_rst_latency", lat, 4);
        wait_idle();

        // Accumulator overflow: 32 x 16384 reaches 2^19
        push(OVF, 0, 0, 1'b0, 2'b10);
        push(0, 0, 1, 1'b1, 2'b00);
        for (int k = 0; k < 32; k++) begin
            send(-128, 0, -128, 0, k == 31);
        end
        wait_valid(lat);
        wait_idle();

        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
